// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the multi-read-port register file:
//   - default register width / index width / read-port count
//   - pendCntWidth(): width of the pending-register counter for a given
//     index width (one extra bit so a completely pending file never wraps)
//   - rdAddrVec_t: packed read-address vector for the default configuration
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int DEFAULT_NUM_RD = 2;

  // Counter must hold 2**addrW, which needs addrW+1 bits.
  function automatic int pendCntWidth(input int addrW);
    return addrW + 1;
  endfunction

  typedef logic [DEFAULT_NUM_RD*DEFAULT_ADDR_W-1:0] rdAddrVec_t;

endpackage

// File: rtl/regfile_if.sv
// regfile_if
// Bundles the register-file read ports, write port, reservation strobe and
// pending count.
//   rd_addr    : NUM_RD packed read addresses (port i at [i*ADDR_W +: ADDR_W])
//   rd_data    : NUM_RD packed read data
//   rd_pending : per-port pending bit of the addressed register
//   wr_en/wr_addr/wr_data : synchronous write port
//   resv_en/resv_addr     : reservation (mark pending) strobe
//   pend_cnt   : number of registers currently pending
// Modports: master = datapath side, slave = register file side.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NUM_RD = DEFAULT_NUM_RD
);

  logic [NUM_RD*ADDR_W-1:0]        rd_addr;
  logic [NUM_RD*DATA_W-1:0]        rd_data;
  logic [NUM_RD-1:0]               rd_pending;
  logic                            wr_en;
  logic [ADDR_W-1:0]               wr_addr;
  logic [DATA_W-1:0]               wr_data;
  logic                            resv_en;
  logic [ADDR_W-1:0]               resv_addr;
  logic [pendCntWidth(ADDR_W)-1:0] pend_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, resv_en, resv_addr,
    input  rd_data, rd_pending, pend_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, resv_en, resv_addr,
    output rd_data, rd_pending, pend_cnt
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// One pending bit per register plus a registered population count of them.
//   clk, reset_n   : clock, asynchronous active-low reset
//   i_setEn/i_setAddr : mark a register pending (wins over a same-edge clear)
//   i_clrEn/i_clrAddr : clear a register's pending bit
//   i_lookupAddr   : NUM_RD packed lookup addresses
//   o_pending      : pending bit per lookup port
//   o_pendCnt      : number of pending registers
// With ZERO_REG=1, address 0 is never set or cleared, so it always reads 0.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int NUM_RD   = DEFAULT_NUM_RD,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            i_setEn,
  input  logic [ADDR_W-1:0]               i_setAddr,
  input  logic                            i_clrEn,
  input  logic [ADDR_W-1:0]               i_clrAddr,
  input  logic [NUM_RD*ADDR_W-1:0]        i_lookupAddr,
  output logic [NUM_RD-1:0]               o_pending,
  output logic [pendCntWidth(ADDR_W)-1:0] o_pendCnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = pendCntWidth(ADDR_W);

  logic [DEPTH-1:0] r_pend;
  logic [CNT_W-1:0] r_pendCnt;

  logic w_setValid;
  logic w_clrValid;
  logic w_inc;
  logic w_dec;

  assign w_setValid = i_setEn && !(ZERO_REG && (i_setAddr == '0));
  assign w_clrValid = i_clrEn && !(ZERO_REG && (i_clrAddr == '0));

  // Count only real transitions: re-reserving a pending register adds
  // nothing, and a clear overridden by a same-address set removes nothing.
  assign w_inc = w_setValid && !r_pend[i_setAddr];
  assign w_dec = w_clrValid && r_pend[i_clrAddr] &&
                 !(w_setValid && (i_setAddr == i_clrAddr));

  // The set is issued after the clear so it takes priority on a collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend    <= '0;
      r_pendCnt <= '0;
    end else begin
      if (w_clrValid) r_pend[i_clrAddr] <= 1'b0;
      if (w_setValid) r_pend[i_setAddr] <= 1'b1;
      r_pendCnt <= r_pendCnt + CNT_W'(w_inc) - CNT_W'(w_dec);
    end
  end

  always_comb begin
    o_pending = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      o_pending[p] = r_pend[i_lookupAddr[p*ADDR_W +: ADDR_W]];
    end
  end

  assign o_pendCnt = r_pendCnt;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Parametrised register file with NUM_RD combinational read ports, one
// synchronous write port and a pending scoreboard for in-flight producers.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset (clears data, pending, count)
//   bus     : regfile_if slave (read ports, write port, reservation, count)
// Optional macro REGFILE_BYPASS_EN: a write is forwarded to any read port
// addressing the written register in the same cycle, and that port's pending
// bit reads 0 unless a same-address reservation happens on that edge.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int NUM_RD   = DEFAULT_NUM_RD,
  parameter bit ZERO_REG = 1'b1
) (
  input logic     clk,
  input logic     reset_n,
  regfile_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]        r_mem [DEPTH];
  logic                     w_wrValid;
  logic [NUM_RD-1:0]        w_sbPending;
  logic [NUM_RD*DATA_W-1:0] w_rdData;
  logic [NUM_RD-1:0]        w_rdPending;

  // Writes to the hard-wired zero register are dropped.
  assign w_wrValid = bus.wr_en && !(ZERO_REG && (bus.wr_addr == '0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wrValid) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Reservations set pending, writes retire it.
  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_setEn      (bus.resv_en),
    .i_setAddr    (bus.resv_addr),
    .i_clrEn      (bus.wr_en),
    .i_clrAddr    (bus.wr_addr),
    .i_lookupAddr (bus.rd_addr),
    .o_pending    (w_sbPending),
    .o_pendCnt    (bus.pend_cnt)
  );

  // Read muxes; register 0 is masked to zero when it is hard-wired.
  always_comb begin
    w_rdData    = '0;
    w_rdPending = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (ZERO_REG && (bus.rd_addr[p*ADDR_W +: ADDR_W] == '0)) begin
        w_rdData[p*DATA_W +: DATA_W] = '0;
      end else begin
        w_rdData[p*DATA_W +: DATA_W] = r_mem[bus.rd_addr[p*ADDR_W +: ADDR_W]];
      end
      w_rdPending[p] = w_sbPending[p];
`ifdef REGFILE_BYPASS_EN
      // A same-address reservation means a newer producer is outstanding,
      // so the stored pending bit is shown rather than the retiring write.
      if (w_wrValid && (bus.rd_addr[p*ADDR_W +: ADDR_W] == bus.wr_addr)) begin
        w_rdData[p*DATA_W +: DATA_W] = bus.wr_data;
        w_rdPending[p] = (bus.resv_en && (bus.resv_addr == bus.wr_addr)) ?
                         w_sbPending[p] : 1'b0;
      end
`endif
    end
  end

  assign bus.rd_data    = w_rdData;
  assign bus.rd_pending = w_rdPending;

endmodule
